// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract unit.
// Defines the opcode and FSM state encodings.
// No timing or flow-control behaviour lives here.
package addsub_pkg;

  localparam int OPW = 2;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_digit.sv
// D-bit ripple adder slice built from full adders; one digit per clock in the serial unit.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the digits.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_digit #(
  parameter int D = 2
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  logic [D:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < D; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Carry into the slice MSB; only meaningful on the final digit, where it feeds V.
  assign cout     = c[D];
  assign c_msb_in = c[D-1];
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial ADD/SUB/CMP/RSB, D bits per clock, registered NZCV; ADDSUB_SAT_EN adds signed saturation of R.
// Latency: M/D + 1 cycles from start to a one-cycle done pulse.
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int M = 8,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [M-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   R,
  output logic           C,
  output logic           N,
  output logic           V,
  output logic           Z
);
  localparam int ND = M / D;
  localparam int CW = $clog2(ND + 1);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t         state, state_nxt;
  op_t            op_q;
  op_t            op_in;
  logic [M-1:0]   x_sr, y_sr, res_sr;
  logic [M-1:0]   raw_nxt, r_commit;
  logic           cy;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last_dig;
  logic [D-1:0]   dg_sum;
  logic           dg_cout, dg_cmsb;

  assign op_in    = op_t'(op);
  assign last_dig = (cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  addsub_digit #(.D(D)) u_digit (
    .x        (x_sr[D-1:0]),
    .y        (y_sr[D-1:0]),
    .cin      (cy),
    .sum      (dg_sum),
    .cout     (dg_cout),
    .c_msb_in (dg_cmsb)
  );

  // New digit enters at the top; after M/D shifts the full result is aligned.
  assign raw_nxt = (res_sr >> D) | (M'(dg_sum) << (M - D));

`ifdef ADDSUB_SAT_EN
  always_comb begin
    r_commit = raw_nxt;
    if (dg_cmsb ^ dg_cout) begin
      r_commit = raw_nxt[M-1] ? {1'b0, {(M-1){1'b1}}} : {1'b1, {(M-1){1'b0}}};
    end
  end
`else
  assign r_commit = raw_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_ADD;
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      R      <= '0;
      C      <= 1'b0;
      N      <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
    end else if (accept) begin
      // Subtraction is X + ~Y + 1; RSB swaps the operands first.
      op_q   <= op_in;
      x_sr   <= (op_in == OP_RSB) ? B : A;
      y_sr   <= (op_in == OP_ADD) ? B : ((op_in == OP_RSB) ? ~A : ~B);
      cy     <= (op_in != OP_ADD);
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      x_sr   <= x_sr >> D;
      y_sr   <= y_sr >> D;
      cy     <= dg_cout;
      res_sr <= raw_nxt;
      cnt    <= cnt + CW'(1);
      if (last_dig) begin
        C <= dg_cout;
        N <= raw_nxt[M-1];
        V <= dg_cmsb ^ dg_cout;
        Z <= (raw_nxt == '0);
        if (op_q != OP_CMP) R <= r_commit;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed-vector bench for addsub_serial over several (M, D) configurations.
module tb_addsub_serial;
  import addsub_pkg::*;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk, rst;

  logic        st4, st88, st16, st8;
  logic [1:0]  op4, op88, op16, op8;
  logic [3:0]  a4, b4;
  logic [7:0]  a88, b88;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;

  logic        bz4, dn4, c4, n4, v4, z4;
  logic        bz88, dn88, c88, n88, v88, z88;
  logic        bz16, dn16, c16, n16, v16, z16;
  logic        bz8, dn8, c8, n8, v8, z8;
  logic [3:0]  r4;
  logic [7:0]  r88;
  logic [15:0] r16;
  logic [7:0]  r8;

  logic [15:0] sw_r    [4];
  logic [3:0]  sw_f    [4];
  logic        sw_done [4];
  logic        sw_busy [4];

  int n_cmp = 0;
  int n_err = 0;

  addsub_serial #(.M(4), .D(1)) u_m4d1 (
    .clk(clk), .rst(rst), .start(st4), .op(op4), .A(a4), .B(b4),
    .busy(bz4), .done(dn4), .R(r4), .C(c4), .N(n4), .V(v4), .Z(z4));

  addsub_serial #(.M(8), .D(8)) u_m8d8 (
    .clk(clk), .rst(rst), .start(st88), .op(op88), .A(a88), .B(b88),
    .busy(bz88), .done(dn88), .R(r88), .C(c88), .N(n88), .V(v88), .Z(z88));

  addsub_serial #(.M(16), .D(4)) u_m16d4 (
    .clk(clk), .rst(rst), .start(st16), .op(op16), .A(a16), .B(b16),
    .busy(bz16), .done(dn16), .R(r16), .C(c16), .N(n16), .V(v16), .Z(z16));

  addsub_serial #(.M(8), .D(2)) u_dut (
    .clk(clk), .rst(rst), .start(st8), .op(op8), .A(a8), .B(b8),
    .busy(bz8), .done(dn8), .R(r8), .C(c8), .N(n8), .V(v8), .Z(z8));

  assign sw_r[0] = {12'h000, r4};
  assign sw_r[1] = {8'h00, r88};
  assign sw_r[2] = r16;
  assign sw_r[3] = {8'h00, r8};
  assign sw_f[0] = {c4, n4, v4, z4};
  assign sw_f[1] = {c88, n88, v88, z88};
  assign sw_f[2] = {c16, n16, v16, z16};
  assign sw_f[3] = {c8, n8, v8, z8};
  assign sw_done[0] = dn4;
  assign sw_done[1] = dn88;
  assign sw_done[2] = dn16;
  assign sw_done[3] = dn8;
  assign sw_busy[0] = bz4;
  assign sw_busy[1] = bz88;
  assign sw_busy[2] = bz16;
  assign sw_busy[3] = bz8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op on instance k, then check latency, busy length, R and {C,N,V,Z}.
  task automatic sw_run(input int k, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [3:0] ef, input int elat, input string tag);
    int lat;
    int bc;
    @(negedge clk);
    case (k)
      0:       begin st4 = 1'b1;  op4 = o;  a4 = a[3:0];  b4 = b[3:0];  end
      1:       begin st88 = 1'b1; op88 = o; a88 = a[7:0]; b88 = b[7:0]; end
      2:       begin st16 = 1'b1; op16 = o; a16 = a;      b16 = b;      end
      default: begin st8 = 1'b1;  op8 = o;  a8 = a[7:0];  b8 = b[7:0];  end
    endcase
    @(negedge clk);
    st4 = 1'b0; st88 = 1'b0; st16 = 1'b0; st8 = 1'b0;
    lat = 1;
    bc  = 0;
    while (!sw_done[k] && lat < 40) begin
      if (sw_busy[k]) bc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy_cycles"}, bc, elat - 1);
    chk({tag, "_busy_at_done"}, sw_busy[k], 1'b0);
    chk({tag, "_r"}, sw_r[k], er);
    chk({tag, "_flags"}, sw_f[k], ef);
  endtask

  initial begin
    int bc;
    int lat;
    int seen;
    rst = 1'b1;
    st4 = 0; st88 = 0; st16 = 0; st8 = 0;
    op4 = 0; op88 = 0; op16 = 0; op8 = 0;
    a4 = 0; b4 = 0; a88 = 0; b88 = 0; a16 = 0; b16 = 0; a8 = 0; b8 = 0;
    #1;
    chk("rst_busy", bz8, 1'b0);
    chk("rst_done", dn8, 1'b0);
    chk("rst_r", r8, 8'h00);
    chk("rst_flags", {c8, n8, v8, z8}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // M=8, D=2 directed operations
    sw_run(3, OP_ADD, 16'h7F, 16'h01, SAT ? 16'h7F : 16'h80, 4'b0110, 5, "add_ovf");
    sw_run(3, OP_SUB, 16'h05, 16'h05, 16'h00, 4'b1001, 5, "sub_eq");
    sw_run(3, OP_SUB, 16'h03, 16'h05, 16'hFE, 4'b0100, 5, "sub_neg");
    sw_run(3, OP_CMP, 16'h10, 16'h20, 16'hFE, 4'b0100, 5, "cmp_lt");
    sw_run(3, OP_RSB, 16'h10, 16'h20, 16'h10, 4'b1000, 5, "rsb");
    sw_run(3, OP_CMP, 16'h05, 16'h05, 16'h10, 4'b1001, 5, "cmp_eq");
    sw_run(3, OP_SUB, 16'h80, 16'h01, SAT ? 16'h80 : 16'h7F, 4'b1010, 5, "sub_ovf");

    // start held high; operand/op changes during RUN must be ignored, DONE-cycle start re-issues
    @(negedge clk);
    st8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h02;
    bc = 0;
    repeat (4) begin
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h33; op8 = OP_SUB;
      if (bz8) bc++;
    end
    chk("hold_busy_cycles", bc, 4);
    @(negedge clk);
    chk("hold_done", dn8, 1'b1);
    chk("hold_r", r8, 8'h03);
    a8 = 8'h10; b8 = 8'h01; op8 = OP_ADD;
    @(negedge clk);
    st8 = 1'b0;
    lat = 6;
    while (!dn8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_done_cycle", lat, 10);
    chk("b2b_r", r8, 8'h11);
    @(negedge clk);
    chk("done_pulse_width", dn8, 1'b0);
    chk("idle_after_done", bz8, 1'b0);

    // reset in the middle of RUN
    @(negedge clk);
    st8 = 1'b1; op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bz8, 1'b0);
    chk("midrst_done", dn8, 1'b0);
    chk("midrst_r", r8, 8'h00);
    chk("midrst_flags", {c8, n8, v8, z8}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn8) seen++;
    end
    chk("midrst_no_done", seen, 0);
    sw_run(3, OP_ADD, 16'h12, 16'h34, 16'h46, 4'b0000, 5, "post_rst");

    // M=4, D=1
    sw_run(0, OP_ADD, 16'h7, 16'h1, SAT ? 16'h7 : 16'h8, 4'b0110, 5, "m4_add_ovf");
    sw_run(0, OP_SUB, 16'h3, 16'h5, 16'hE, 4'b0100, 5, "m4_sub");
    sw_run(0, OP_RSB, 16'h9, 16'h2, SAT ? 16'h7 : 16'h9, 4'b0110, 5, "m4_rsb_ovf");
    sw_run(0, OP_ADD, 16'hF, 16'h1, 16'h0, 4'b1001, 5, "m4_add_wrap");

    // M=8, D=8
    sw_run(1, OP_ADD, 16'hFF, 16'h01, 16'h00, 4'b1001, 2, "m8d8_add_wrap");
    sw_run(1, OP_SUB, 16'h00, 16'h01, 16'hFF, 4'b0100, 2, "m8d8_sub");
    sw_run(1, OP_ADD, 16'h40, 16'h40, SAT ? 16'h7F : 16'h80, 4'b0110, 2, "m8d8_add_ovf");

    // M=16, D=4
    sw_run(2, OP_ADD, 16'h1234, 16'h4321, 16'h5555, 4'b0000, 5, "m16_add");
    sw_run(2, OP_SUB, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 4'b1010, 5, "m16_sub_ovf");
    sw_run(2, OP_RSB, 16'h1000, 16'h0FFF, 16'hFFFF, 4'b0100, 5, "m16_rsb");
    sw_run(2, OP_CMP, 16'hABCD, 16'hABCD, 16'hFFFF, 4'b1001, 5, "m16_cmp");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
